// File: rtl/ext_mem_arbiter_if.sv
// Per-master request/response bundle for the external memory arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface ext_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;
    logic                  err;

    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter sharing the external memory bus between the CPU (m0) and DMA (m1).
// Serves one transfer at a time, inserts wait states and returns err after a bounded timeout.
module ext_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ext_mem_arbiter_if.slave      m0,
    ext_mem_arbiter_if.slave      m1,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    inout  wire  [DATA_WIDTH-1:0] ext_data,
    output logic                  ext_mem_read,
    output logic                  ext_mem_write,
    output logic                  ext_mem_enable,
    input  logic                  ext_mem_ready,
    output logic                  busy,
    output logic                  grant_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state;
    logic                  grant;
    logic                  last_grant;
    logic                  lat_we;
    logic                  res_err;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  winner;
    logic                  in_access;
    logic                  in_done;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        // NOTE: a default assignment first keeps every path covered, so no latch is inferred.
        winner = m1.req;
        if (m0.req && m1.req)
            winner = ~last_grant;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; the read-data registers are cleared too because they are outputs.
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            res_err    <= 1'b0;
            cnt        <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0.req || m1.req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        lat_we     <= winner ? m1.we    : m0.we;
                        lat_addr   <= winner ? m1.addr  : m0.addr;
                        lat_wdata  <= winner ? m1.wdata : m0.wdata;
                        res_err    <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (ext_mem_ready) begin
                        if (!lat_we) begin
                            if (grant) rdata1 <= ext_data;
                            else       rdata0 <= ext_data;
                        end
                        res_err <= 1'b0;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        res_err <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign in_done   = (state == ST_DONE);

    // Bus strobes decode only registered state and latched request, so they cannot glitch.
    assign ext_mem_enable = in_access;
    assign ext_mem_read   = in_access & ~lat_we;
    assign ext_mem_write  = in_access &  lat_we;
    assign ext_addr       = in_access ? lat_addr : '0;
    assign ext_data       = (in_access && lat_we) ? lat_wdata : {DATA_WIDTH{1'bz}};

    assign busy     = in_access | in_done;
    assign grant_id = busy & grant;

    assign m0.ack   = in_done & ~res_err & ~grant;
    assign m0.err   = in_done &  res_err & ~grant;
    assign m1.ack   = in_done & ~res_err &  grant;
    assign m1.err   = in_done &  res_err &  grant;
    assign m0.rdata = rdata0;
    assign m1.rdata = rdata1;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: a word-addressed memory model with programmable wait
// states sits on the external bus, and bus monitors count strobes, pulses and protocol violations.
module tb_ext_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ext_addr;
    wire  [31:0] ext_data;
    logic        ext_mem_read;
    logic        ext_mem_write;
    logic        ext_mem_enable;
    logic        ext_mem_ready;
    logic        busy;
    logic        grant_id;

    ext_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    ext_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();

    ext_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(255),
        .CNT_WIDTH     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0            (m0_bus),
        .m1            (m1_bus),
        .ext_addr      (ext_addr),
        .ext_data      (ext_data),
        .ext_mem_read  (ext_mem_read),
        .ext_mem_write (ext_mem_write),
        .ext_mem_enable(ext_mem_enable),
        .ext_mem_ready (ext_mem_ready),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    // Memory model: 4096 words, ready after wait_states ACCESS cycles unless never_ready.
    logic [31:0] mem [0:4095];
    logic        never_ready;
    int          wait_states;
    int          acc_cnt;
    logic        pre_we;
    logic [11:0] pre_idx;
    logic [31:0] pre_val;

    assign ext_data      = ext_mem_read ? mem[ext_addr[13:2]] : 32'hzzzz_zzzz;
    assign ext_mem_ready = ext_mem_enable && !never_ready && (acc_cnt >= wait_states);

    always @(posedge clk) begin
        acc_cnt <= ext_mem_enable ? acc_cnt + 1 : 0;
        if (pre_we)
            mem[pre_idx] <= pre_val;
        else if (ext_mem_enable && ext_mem_write && ext_mem_ready)
            mem[ext_addr[13:2]] <= ext_data;
    end

    // Bus monitors sampled mid-cycle.
    int          n_ack0 = 0, n_ack1 = 0, n_err0 = 0, n_err1 = 0;
    int          n_wr_cyc = 0, n_wdata_bad = 0, n_viol = 0;
    logic [31:0] exp_wdata;

    always @(negedge clk) begin
        if (m0_bus.ack) n_ack0 <= n_ack0 + 1;
        if (m1_bus.ack) n_ack1 <= n_ack1 + 1;
        if (m0_bus.err) n_err0 <= n_err0 + 1;
        if (m1_bus.err) n_err1 <= n_err1 + 1;
        if ((32'(m0_bus.ack) + 32'(m1_bus.ack) + 32'(m0_bus.err) + 32'(m1_bus.err)) > 1
            || (ext_mem_read && ext_mem_write))
            n_viol <= n_viol + 1;
        if (ext_mem_write) begin
            n_wr_cyc <= n_wr_cyc + 1;
            if (ext_data !== exp_wdata) n_wdata_bad <= n_wdata_bad + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        step();
        pre_we  = 1'b0;
    endtask

    // Returns in the response cycle; who = -1 if nothing answered within the budget.
    task automatic wait_resp(input int budget, output int who, output logic is_err,
                             output int cycles);
        who    = -1;
        is_err = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            cycles++;
            if (m0_bus.ack || m0_bus.err) begin
                who = 0; is_err = m0_bus.err; break;
            end
            if (m1_bus.ack || m1_bus.err) begin
                who = 1; is_err = m1_bus.err; break;
            end
        end
    endtask

    task automatic set_req(input int m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        if (m == 0) begin
            m0_bus.req = 1'b1; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata;
        end else begin
            m1_bus.req = 1'b1; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   who, cycles, snap_a, snap_b, snap_c;
        int   rem0, rem1;
        logic is_err;

        rst_n       = 1'b0;
        never_ready = 1'b0;
        wait_states = 0;
        pre_we      = 1'b0;
        pre_idx     = '0;
        pre_val     = '0;
        exp_wdata   = '0;
        m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0;
        m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0;

        poke(12'h400, 32'h0000_2710);   // 0x1000
        poke(12'h040, 32'h0000_00A0);   // 0x0100
        poke(12'h080, 32'h0000_00B1);   // 0x0200
        poke(12'h0C0, 32'h0);           // 0x0300
        poke(12'h100, 32'h0);           // 0x0400
        poke(12'h800, 32'h0);           // 0x2000

        check("rst_enable", 32'(ext_mem_enable), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_grant",  32'(grant_id), 0);
        check("rst_acks",   32'(m0_bus.ack | m1_bus.ack | m0_bus.err | m1_bus.err), 0);
        check("rst_rdata0", m0_bus.rdata, 0);
        check("rst_rdata1", m1_bus.rdata, 0);
        rst_n = 1'b1;
        step();

        // 1) single read, zero wait states
        set_req(0, 1'b0, 32'h1000, 32'h0);
        step();
        check("t1_enable", 32'(ext_mem_enable), 1);
        check("t1_read",   32'(ext_mem_read), 1);
        check("t1_write",  32'(ext_mem_write), 0);
        check("t1_addr",   ext_addr, 32'h1000);
        wait_resp(10, who, is_err, cycles);
        m0_bus.req = 1'b0;
        check("t1_who",    32'(who), 0);
        check("t1_err",    32'(is_err), 0);
        check("t1_cycles", 32'(cycles), 1);
        check("t1_rdata",  m0_bus.rdata, 32'h2710);
        check("t1_strobe_off", 32'(ext_mem_enable), 0);
        step();
        check("t1_ack_pulse", 32'(m0_bus.ack), 0);
        check("t1_idle",   32'(busy), 0);

        // 2) both masters contend for four transfers
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        rem0 = 2;
        rem1 = 2;
        set_req(0, 1'b0, 32'h0100, 32'h0);
        set_req(1, 1'b0, 32'h0200, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_resp(20, who, is_err, cycles);
            check($sformatf("t2_who_%0d", k), 32'(who), 32'(k % 2));
            check($sformatf("t2_gid_%0d", k), 32'(grant_id), 32'(k % 2));
            check($sformatf("t2_err_%0d", k), 32'(is_err), 0);
            if (who == 0) begin
                check($sformatf("t2_rdata_%0d", k), m0_bus.rdata, 32'hA0);
                rem0--;
                m0_bus.req = (rem0 > 0);
            end else begin
                check($sformatf("t2_rdata_%0d", k), m1_bus.rdata, 32'hB1);
                rem1--;
                m1_bus.req = (rem1 > 0);
            end
        end
        step();
        step();
        check("t2_drained", 32'(busy), 0);

        // 3) write with five wait states
        wait_states = 5;
        exp_wdata   = 32'h1;
        snap_a      = n_wr_cyc;
        snap_b      = n_wdata_bad;
        set_req(1, 1'b1, 32'h2000, 32'h1);
        wait_resp(20, who, is_err, cycles);
        m1_bus.req = 1'b0;
        check("t3_who",    32'(who), 1);
        check("t3_err",    32'(is_err), 0);
        check("t3_cycles", 32'(cycles), 7);
        step();
        check("t3_wr_cycles", 32'(n_wr_cyc - snap_a), 6);
        check("t3_wdata",     32'(n_wdata_bad - snap_b), 0);
        check("t3_mem",       mem[12'h800], 32'h1);

        // 4) memory never ready: timeout then normal service
        wait_states = 0;
        never_ready = 1'b1;
        snap_a      = n_ack0;
        snap_b      = n_err0;
        set_req(0, 1'b0, 32'h1000, 32'h0);
        wait_resp(300, who, is_err, cycles);
        m0_bus.req = 1'b0;
        check("t4_who",    32'(who), 0);
        check("t4_err",    32'(is_err), 1);
        check("t4_cycles", 32'(cycles), 256);
        step();
        check("t4_idle",   32'(busy), 0);
        check("t4_no_ack", 32'(n_ack0 - snap_a), 0);
        check("t4_one_err", 32'(n_err0 - snap_b), 1);
        never_ready = 1'b0;
        set_req(0, 1'b0, 32'h1000, 32'h0);
        wait_resp(10, who, is_err, cycles);
        m0_bus.req = 1'b0;
        check("t4_rec_who",    32'(who), 0);
        check("t4_rec_err",    32'(is_err), 0);
        check("t4_rec_cycles", 32'(cycles), 2);
        check("t4_rec_rdata",  m0_bus.rdata, 32'h2710);
        step();

        // 5) reset in the middle of a write access
        never_ready = 1'b1;
        exp_wdata   = 32'h55;
        snap_c      = n_ack0 + n_ack1 + n_err0 + n_err1;
        set_req(0, 1'b1, 32'h0300, 32'h55);
        step();
        step();
        step();
        check("t5_in_access", 32'(ext_mem_write), 1);
        rst_n = 1'b0;
        step();
        m0_bus.req = 1'b0;
        check("t5_enable", 32'(ext_mem_enable), 0);
        check("t5_write",  32'(ext_mem_write), 0);
        check("t5_read",   32'(ext_mem_read), 0);
        check("t5_busy",   32'(busy), 0);
        step();
        step();
        rst_n       = 1'b1;
        never_ready = 1'b0;
        step();
        check("t5_no_resp", 32'(n_ack0 + n_ack1 + n_err0 + n_err1 - snap_c), 0);
        check("t5_mem",     mem[12'h0C0], 32'h0);
        set_req(0, 1'b0, 32'h1000, 32'h0);
        set_req(1, 1'b0, 32'h0200, 32'h0);
        wait_resp(10, who, is_err, cycles);
        m0_bus.req = 1'b0;
        check("t5_tie_m0", 32'(who), 0);
        wait_resp(10, who, is_err, cycles);
        m1_bus.req = 1'b0;
        check("t5_then_m1", 32'(who), 1);
        step();

        // 6) m0 drops req mid-access while m1 waits
        wait_states = 3;
        snap_a      = n_ack0;
        set_req(0, 1'b0, 32'h0100, 32'h0);
        step();
        exp_wdata = 32'h77;
        set_req(1, 1'b1, 32'h0400, 32'h77);
        step();
        m0_bus.req = 1'b0;
        wait_resp(20, who, is_err, cycles);
        check("t6_first",  32'(who), 0);
        check("t6_rdata",  m0_bus.rdata, 32'hA0);
        wait_resp(20, who, is_err, cycles);
        m1_bus.req = 1'b0;
        check("t6_second", 32'(who), 1);
        check("t6_err",    32'(is_err), 0);
        step();
        step();
        check("t6_one_ack", 32'(n_ack0 - snap_a), 1);
        check("t6_mem",     mem[12'h100], 32'h77);

        check("exclusive_pulses", 32'(n_viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
